// File: rtl/audio_pwm_out.sv
// audio_pwm_out: audio output stage after the AM receiver.
// Removes residual DC, applies a power-of-two volume gain with saturation,
// and drives a single-bit PWM DAC pin. Sparse samples are held in a one-deep
// pending register that is consumed at PWM frame boundaries; overwriting an
// unconsumed sample raises a sticky overrun flag.
// Optional feature: define AUDIO_DC_BLOCK_EN to enable the DC-tracking
// high-pass in stage 1. When undefined, stage 1 only registers the sign-extended
// sample, so the pipeline latency is the same in both builds.
module audio_pwm_out #(
  parameter int DATA_WIDTH   = 12,
  parameter int PWM_WIDTH    = 10,
  parameter int DC_SHIFT     = 10,
  parameter int VOLUME_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           in_valid,
  input  logic signed [DATA_WIDTH-1:0]   in_data,
  input  logic        [VOLUME_WIDTH-1:0] volume,
  input  logic                           overrun_clr,
  output logic                           pwm_out,
  output logic                           sample_loaded,
  output logic                           overrun
);

  // High-pass result width and full-precision gain width.
  localparam int HW = DATA_WIDTH + 1;
  localparam int GW = HW + (1 << VOLUME_WIDTH) - 1;

  // Saturation limits of the signed DATA_WIDTH range, expressed at gain width.
  localparam logic signed [GW-1:0] GMAX = {{(GW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [GW-1:0] GMIN = {{(GW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Frame duty at reset: midscale, i.e. silence.
  localparam logic [PWM_WIDTH-1:0] DUTY_MID = {1'b1, {(PWM_WIDTH-1){1'b0}}};

  if (PWM_WIDTH > DATA_WIDTH || PWM_WIDTH < 2 || DC_SHIFT < 1 || VOLUME_WIDTH < 1) begin : g_bad_params
    $error("audio_pwm_out: illegal parameter combination");
  end

  // Stage 1 state
  logic                    r_v1;
  logic signed [HW-1:0]    r_hp;
  logic [VOLUME_WIDTH-1:0] r_vol1;
  logic signed [HW-1:0]    w_hp;

  // Stage 2 state: only the bits that reach the PWM duty are kept
  logic                    r_v2;
  logic [PWM_WIDTH-1:0]    r_gtop;
  logic signed [GW-1:0]    w_ext;
  logic signed [GW-1:0]    w_g;
  logic [PWM_WIDTH-1:0]    w_gtop;

  // Pending register and PWM frame state
  logic [PWM_WIDTH-1:0]    r_pend;
  logic                    r_pend_v;
  logic [PWM_WIDTH-1:0]    r_count;
  logic [PWM_WIDTH-1:0]    r_duty;
  logic [PWM_WIDTH-1:0]    w_u;
  logic                    w_bnd;
  logic                    w_consume;

`ifdef AUDIO_DC_BLOCK_EN
  localparam int AW = DATA_WIDTH + DC_SHIFT + 1;

  logic signed [AW-1:0] r_acc;

  // The top HW bits of the accumulator are exactly acc >>> DC_SHIFT truncated
  // to HW bits, so the DC estimate is taken as a slice rather than a shift.
  assign w_hp = $signed({in_data[DATA_WIDTH-1], in_data}) - $signed(r_acc[AW-1 -: HW]);

  // DC tracker: integrate the high-pass output on every accepted sample.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_acc <= '0;
    end else if (in_valid) begin
      r_acc <= r_acc + {{(AW-HW){w_hp[HW-1]}}, w_hp};
    end
  end
`else
  assign w_hp = {in_data[DATA_WIDTH-1], in_data};
`endif

  // Stage 1: register high-pass sample together with its volume setting.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_v1   <= 1'b0;
      r_hp   <= '0;
      r_vol1 <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_hp   <= w_hp;
        r_vol1 <= volume;
      end
    end
  end

  // Gain at full precision, then saturate and keep the duty-relevant top bits.
  always_comb begin
    w_ext  = {{(GW-HW){r_hp[HW-1]}}, r_hp};
    w_g    = w_ext <<< r_vol1;
    w_gtop = w_g[DATA_WIDTH-1 -: PWM_WIDTH];
    if (w_g > GMAX) begin
      w_gtop = {1'b0, {(PWM_WIDTH-1){1'b1}}};
    end else if (w_g < GMIN) begin
      w_gtop = {1'b1, {(PWM_WIDTH-1){1'b0}}};
    end
  end

  // Stage 2: register the saturated, gained sample.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_v2   <= 1'b0;
      r_gtop <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_gtop <= w_gtop;
      end
    end
  end

  // Offset binary is the signed value with its MSB inverted.
  assign w_u       = {~r_gtop[PWM_WIDTH-1], r_gtop[PWM_WIDTH-2:0]};
  assign w_bnd     = (r_count == {PWM_WIDTH{1'b1}});
  assign w_consume = w_bnd && r_pend_v;

  // Stage 3, pending register, frame counter, duty update and PWM output.
  // A boundary consumes the old pending value in the same cycle a new one may
  // be written, so the write only counts as an overrun off a consuming boundary.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_pend        <= '0;
      r_pend_v      <= 1'b0;
      r_count       <= '0;
      r_duty        <= DUTY_MID;
      pwm_out       <= 1'b0;
      sample_loaded <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      r_count       <= r_count + 1'b1;
      pwm_out       <= (r_count < r_duty);
      sample_loaded <= w_consume;
      if (w_consume) begin
        r_duty <= r_pend;
      end
      if (r_v2) begin
        r_pend   <= w_u;
        r_pend_v <= 1'b1;
      end else if (w_consume) begin
        r_pend_v <= 1'b0;
      end
      if (r_v2 && r_pend_v && !w_bnd) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: directed, table-driven bench for audio_pwm_out.
// Duty is measured as the number of high clocks in the frame that follows a
// sample_loaded pulse. With AUDIO_DC_BLOCK_EN defined the DUT is built with
// DC_SHIFT=4 and the DC-tracking scenario replaces the gain table.
module tb_audio_pwm_out;

  localparam int DW = 12;
  localparam int PW = 10;
  localparam int VW = 3;
`ifdef AUDIO_DC_BLOCK_EN
  localparam int DCS = 4;
`else
  localparam int DCS = 10;
`endif

  logic                 clk = 1'b0;
  logic                 arst_n;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic [VW-1:0]        volume;
  logic                 overrun_clr;
  logic                 pwm_out;
  logic                 sample_loaded;
  logic                 overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  audio_pwm_out #(
    .DATA_WIDTH  (DW),
    .PWM_WIDTH   (PW),
    .DC_SHIFT    (DCS),
    .VOLUME_WIDTH(VW)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .volume       (volume),
    .overrun_clr  (overrun_clr),
    .pwm_out      (pwm_out),
    .sample_loaded(sample_loaded),
    .overrun      (overrun)
  );

  typedef struct {
    int data;
    int vol;
    int duty;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp, input int tol = 0);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic strobe(input int d, input int v);
    in_data  = DW'(d);
    volume   = VW'(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_load(input string name);
    int n = 0;
    while (!sample_loaded && n < 3000) begin
      tick();
      n++;
    end
    check(name, int'(sample_loaded), 1);
  endtask

  task automatic measure(output int highs, output int loads);
    highs = 0;
    loads = 0;
    repeat (1024) begin
      tick();
      highs += int'(pwm_out);
      loads += int'(sample_loaded);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l, h2, l2;
`ifndef AUDIO_DC_BLOCK_EN
    vec_t vecs[15];
    vecs[0]  = '{2047,  0, 1023};
    vecs[1]  = '{-2048, 0, 0};
    vecs[2]  = '{1500,  1, 1023};
    vecs[3]  = '{-1500, 1, 0};
    vecs[4]  = '{100,   2, 612};
    vecs[5]  = '{-5,    0, 510};
    vecs[6]  = '{0,     7, 512};
    vecs[7]  = '{3,     7, 608};
    vecs[8]  = '{-1,    3, 510};
    vecs[9]  = '{511,   2, 1023};
    vecs[10] = '{-513,  2, 0};
    vecs[11] = '{1,     0, 512};
    vecs[12] = '{2047,  7, 1023};
    vecs[13] = '{-2048, 7, 0};
    vecs[14] = '{300,   0, 587};
`endif

    arst_n      = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    volume      = '0;
    overrun_clr = 1'b0;
    tick();
    tick();
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_loaded", int'(sample_loaded), 0);
    check("reset_overrun", int'(overrun), 0);
    arst_n = 1'b1;

    // Idle: midscale duty, nothing loaded
    measure(h, l);
    measure(h2, l2);
    check("idle_frame0_high", h, 512);
    check("idle_frame1_high", h2, 512);
    check("idle_loads", l + l2, 0);
    check("idle_overrun", int'(overrun), 0);

`ifndef AUDIO_DC_BLOCK_EN
    foreach (vecs[i]) begin
      strobe(vecs[i].data, vecs[i].vol);
      wait_load($sformatf("vec%0d_load", i));
      measure(h, l);
      check($sformatf("vec%0d_duty", i), h, vecs[i].duty);
      check($sformatf("vec%0d_extra_loads", i), l, 0);
      check($sformatf("vec%0d_overrun", i), int'(overrun), 0);
    end

    // Two strobes 5 clocks apart inside one frame: overrun, newer sample wins
    strobe(1500, 0);
    repeat (4) tick();
    strobe(400, 0);
    repeat (4) tick();
    check("ovr_set", int'(overrun), 1);
    wait_load("ovr_load");
    measure(h, l);
    check("ovr_second_duty", h, 612);

    // Clear coinciding with a new overrun event: set wins
    strobe(0, 0);
    repeat (4) tick();
    strobe(-400, 0);
    tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_set_beats_clr", int'(overrun), 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_lone_clr", int'(overrun), 0);
    wait_load("ovr2_load");
    measure(h, l);
    check("ovr2_duty", h, 412);

    // Stage-3 write lands exactly on a consuming frame boundary (count is 0 here)
    strobe(1000, 0);
    repeat (1020) tick();
    strobe(-1000, 0);
    tick();
    tick();
    check("simul_loaded", int'(sample_loaded), 1);
    check("simul_overrun", int'(overrun), 0);
    measure(h, l);
    check("simul_old_duty", h, 762);
    check("simul_new_loaded", l, 1);
    measure(h, l);
    check("simul_new_duty", h, 262);
    check("simul_overrun_after", int'(overrun), 0);
`else
    // DC tracker with DC_SHIFT=4 and a constant input
    strobe(1000, 0);
    wait_load("dc_first_load");
    measure(h, l);
    check("dc_first_duty", h, 762);
    for (int k = 0; k < 199; k++) begin
      strobe(1000, 0);
      repeat (3) tick();
    end
    tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    wait_load("dc_settled_load");
    measure(h, l);
    check("dc_settled_duty", h, 512, 1);
    check("dc_overrun_cleared", int'(overrun), 0);
`endif

    // Mid-frame reset with a pending sample, overrun set and one in flight
    strobe(2047, 0);
    repeat (4) tick();
    strobe(2047, 0);
    tick();
    tick();
    check("pre_reset_overrun", int'(overrun), 1);
    strobe(2047, 0);
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_loaded", int'(sample_loaded), 0);
    check("midrst_overrun", int'(overrun), 0);
    measure(h, l);
    check("midrst_duty", h, 512);
    check("midrst_pending_dropped", l, 0);
    measure(h, l);
    check("midrst_duty2", h, 512);
    check("midrst_no_load2", l, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
